// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the write-back commit slice.
//   DATA_W   - result / register file data width
//   ADDR_W   - register address width
//   NREG     - number of architectural registers (2**ADDR_W)
//   wb_req_t - one candidate register file write {valid, addr, data}
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage : cpu_pkg

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Per-register pending bits. A register is marked pending when issue logic
// reserves it and released on the cycle its write is presented to the
// register file.
//   clk        - clock
//   rst        - asynchronous active-low reset, clears every pending bit
//   iss_valid  - issue logic requests a reservation
//   iss_addr   - register being reserved
//   iss_ready  - reservation accepted (register not pending)
//   clr_en     - a write is being committed this cycle
//   clr_addr   - register being written
//   busy       - registered pending bit per register
// ---------------------------------------------------------------------------
module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W_P = ADDR_W,
    parameter int NREG_P   = NREG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic [ADDR_W_P-1:0] iss_addr,
    output logic                iss_ready,
    input  logic                clr_en,
    input  logic [ADDR_W_P-1:0] clr_addr,
    output logic [NREG_P-1:0]   busy
);

    logic [NREG_P-1:0] set_mask;
    logic [NREG_P-1:0] clr_mask;
    logic [NREG_P-1:0] busy_nxt;

    // A second reservation of a pending register waits for its write.
    assign iss_ready = ~busy[iss_addr];

    always_comb begin
        // NOTE: defaults first so every path assigns the masks; otherwise
        // the tool infers latches to hold the unassigned bits.
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid && iss_ready) begin
            set_mask[iss_addr] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_addr] = 1'b1;
        end
    end

    // Clear applied before set, so a same-cycle reservation of the register
    // being written leaves it pending.
    assign busy_nxt = (busy & ~clr_mask) | set_mask;

    // NOTE: busy is a handful of flops rather than a RAM, so it takes the
    // async reset; a reset that leaves stale pending bits would deadlock issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            busy <= busy_nxt;
        end
    end

endmodule : wb_scoreboard

// File: rtl/wb_commit.sv
// ---------------------------------------------------------------------------
// wb_commit
// Write-back commit stage in front of the register file. Arbitrates the
// memory-load and ALU result streams (load has fixed priority) into one
// registered write per cycle and tracks pending destinations so issue logic
// can stall on RAW/WAW hazards.
//   clk, rst              - clock, asynchronous active-low reset
//   iss_valid/addr/ready  - destination reservation from issue logic
//   alu_valid/addr/data   - ALU result, alu_ready = !mem_valid
//   mem_valid/addr/data   - load result, mem_ready always 1
//   wr_en/addr/data       - registered register file write, also the
//                           forwarding source for consumers
//   busy                  - registered pending bit per register
// ---------------------------------------------------------------------------
module wb_commit
    import cpu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int NREG_P   = NREG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic [ADDR_W_P-1:0] iss_addr,
    output logic                iss_ready,
    input  logic                alu_valid,
    input  logic [ADDR_W_P-1:0] alu_addr,
    input  logic [DATA_W_P-1:0] alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W_P-1:0] mem_addr,
    input  logic [DATA_W_P-1:0] mem_data,
    output logic                mem_ready,
    output logic                wr_en,
    output logic [ADDR_W_P-1:0] wr_addr,
    output logic [DATA_W_P-1:0] wr_data,
    output logic [NREG_P-1:0]   busy
);

    wb_req_t alu_req;
    wb_req_t mem_req;
    wb_req_t sel_req;

    assign alu_req = '{valid: alu_valid, addr: alu_addr, data: alu_data};
    assign mem_req = '{valid: mem_valid, addr: mem_addr, data: mem_data};

    // Loads never stall: the load pipe has no holding buffer. The ALU yields.
    assign mem_ready = 1'b1;
    assign alu_ready = ~mem_valid;

    always_comb begin
        sel_req = '0;
        if (mem_req.valid) begin
            sel_req = mem_req;
        end else if (alu_req.valid) begin
            sel_req = alu_req;
        end
    end

    // Address/data only load on an accepted result so the last write stays
    // visible on wr_* while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= sel_req.valid;
            if (sel_req.valid) begin
                wr_addr <= sel_req.addr;
                wr_data <= sel_req.data;
            end
        end
    end

    // Pending bit drops on the edge that ends the wr_en cycle, so a stalled
    // reader resumes exactly when the register file holds the new value.
    wb_scoreboard #(
        .ADDR_W_P (ADDR_W_P),
        .NREG_P   (NREG_P)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .clr_en    (wr_en),
        .clr_addr  (wr_addr),
        .busy      (busy)
    );

    // Committing to an unreserved register is a protocol error upstream; the
    // write still goes through and the scoreboard is left untouched.
    unreserved_write_a : assert property (
        @(posedge clk) disable iff (!rst) wr_en |-> busy[wr_addr]
    ) else $warning("wb_commit: write to unreserved register r%0d", wr_addr);

endmodule : wb_commit

// File: tb/tb_wb_commit.sv
// ---------------------------------------------------------------------------
// tb_wb_commit
// Directed scenarios for wb_commit with hand-computed expected values.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_wb_commit;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [2:0]  iss_addr;
    logic        iss_ready;
    logic        alu_valid;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  busy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_commit dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_addr = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    endtask

    task automatic reserve(input logic [2:0] a);
        iss_valid = 1'b1; iss_addr = a;
        step();
        iss_valid = 1'b0;
    endtask

    task automatic test_reset();
        // build busy = 8'h0F and an in-flight write to r0
        for (int i = 0; i < 4; i++) reserve(3'(i));
        n_tests++;
        if (busy !== 8'h0F) begin
            $display("FAIL reset_pre_busy: got %h expected 0f", busy); n_fail++;
        end
        alu_valid = 1'b1; alu_addr = 3'd0; alu_data = 16'h1234;
        step();
        alu_valid = 1'b0;
        n_tests++;
        if (wr_en !== 1'b1) begin
            $display("FAIL reset_pre_wren: got %b expected 1", wr_en); n_fail++;
        end
        // asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({wr_en, wr_addr, wr_data, busy} !== '0) begin
            $display("FAIL reset_outputs: got wr_en=%b wr_addr=%h wr_data=%h busy=%h expected all 0",
                     wr_en, wr_addr, wr_data, busy);
            n_fail++;
        end
        n_tests++;
        if ({iss_ready, alu_ready, mem_ready} !== 3'b111) begin
            $display("FAIL reset_readies: got %b expected 111", {iss_ready, alu_ready, mem_ready});
            n_fail++;
        end
        step();
        rst = 1'b1;
        step();
        n_tests++;
        if (wr_en !== 1'b0 || busy !== 8'h00) begin
            $display("FAIL reset_release: got wr_en=%b busy=%h expected 0 00", wr_en, busy);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            iss_addr = 3'(i);
            #1;
            n_tests++;
            if (iss_ready !== 1'b1) begin
                $display("FAIL reset_iss_ready_r%0d: got %b expected 1", i, iss_ready); n_fail++;
            end
        end
        iss_addr = '0;
    endtask

    task automatic test_alu_single();
        reserve(3'd3);
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'hBEEF;
        #1;
        n_tests++;
        if (alu_ready !== 1'b1) begin
            $display("FAIL alu_ready: got %b expected 1", alu_ready); n_fail++;
        end
        step();                       // now cycle N+1
        alu_valid = 1'b0;
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== 3'd3 || wr_data !== 16'hBEEF) begin
            $display("FAIL alu_write: got %b/%h/%h expected 1/3/beef", wr_en, wr_addr, wr_data);
            n_fail++;
        end
        n_tests++;
        if (busy[3] !== 1'b1) begin
            $display("FAIL alu_busy_n1: got %b expected 1", busy[3]); n_fail++;
        end
        step();                       // cycle N+2
        n_tests++;
        if (wr_en !== 1'b0 || busy[3] !== 1'b0 || wr_data !== 16'hBEEF || wr_addr !== 3'd3) begin
            $display("FAIL alu_after: got wr_en=%b busy3=%b wr_addr=%h wr_data=%h expected 0 0 3 beef",
                     wr_en, busy[3], wr_addr, wr_data);
            n_fail++;
        end
    endtask

    task automatic test_collision();
        reserve(3'd1);
        reserve(3'd2);
        mem_valid = 1'b1; mem_addr = 3'd1; mem_data = 16'h1111;
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h2222;
        #1;
        n_tests++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            $display("FAIL coll_ready: got alu=%b mem=%b expected 0 1", alu_ready, mem_ready);
            n_fail++;
        end
        step();                       // N+1
        mem_valid = 1'b0;
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== 3'd1 || wr_data !== 16'h1111) begin
            $display("FAIL coll_mem_write: got %b/%h/%h expected 1/1/1111", wr_en, wr_addr, wr_data);
            n_fail++;
        end
        step();                       // N+2
        alu_valid = 1'b0;
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== 3'd2 || wr_data !== 16'h2222) begin
            $display("FAIL coll_alu_write: got %b/%h/%h expected 1/2/2222", wr_en, wr_addr, wr_data);
            n_fail++;
        end
        step();
        n_tests++;
        if (wr_en !== 1'b0 || busy !== 8'h00) begin
            $display("FAIL coll_drain: got wr_en=%b busy=%h expected 0 00", wr_en, busy); n_fail++;
        end
    endtask

    task automatic test_waw_stall();
        reserve(3'd5);
        iss_valid = 1'b1; iss_addr = 3'd5;
        #1;
        n_tests++;
        if (iss_ready !== 1'b0) begin
            $display("FAIL waw_stall0: got %b expected 0", iss_ready); n_fail++;
        end
        step();
        alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'h5555;
        #1;
        n_tests++;
        if (iss_ready !== 1'b0 || busy !== 8'h20) begin
            $display("FAIL waw_stall1: got ready=%b busy=%h expected 0 20", iss_ready, busy); n_fail++;
        end
        step();                       // wr_en on r5
        alu_valid = 1'b0;
        n_tests++;
        if (iss_ready !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 3'd5) begin
            $display("FAIL waw_commit: got ready=%b wr_en=%b wr_addr=%h expected 0 1 5",
                     iss_ready, wr_en, wr_addr);
            n_fail++;
        end
        step();                       // busy cleared, reservation now accepted
        n_tests++;
        if (iss_ready !== 1'b1 || busy[5] !== 1'b0) begin
            $display("FAIL waw_release: got ready=%b busy5=%b expected 1 0", iss_ready, busy[5]);
            n_fail++;
        end
        step();
        iss_valid = 1'b0;
        n_tests++;
        if (busy !== 8'h20) begin
            $display("FAIL waw_reserved: got %h expected 20", busy); n_fail++;
        end
        alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 16'h0005;
        step();
        alu_valid = 1'b0;
        step();
    endtask

    task automatic test_set_clear();
        // unreserved write to r4 lands in the same cycle as a new r4 reservation
        alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 16'h4444;
        step();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_addr = 3'd4;
        #1;
        n_tests++;
        if (wr_en !== 1'b1 || wr_addr !== 3'd4 || iss_ready !== 1'b1) begin
            $display("FAIL sc_setup: got wr_en=%b wr_addr=%h ready=%b expected 1 4 1",
                     wr_en, wr_addr, iss_ready);
            n_fail++;
        end
        step();
        iss_valid = 1'b0;
        n_tests++;
        if (busy !== 8'h10) begin
            $display("FAIL sc_set_wins: got %h expected 10", busy); n_fail++;
        end
        alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 16'h0004;
        step();
        alu_valid = 1'b0;
        step();
        n_tests++;
        if (busy !== 8'h00) begin
            $display("FAIL sc_drain: got %h expected 00", busy); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int run;
        for (int i = 0; i < 8; i++) reserve(3'(i));
        n_tests++;
        if (busy !== 8'hFF) begin
            $display("FAIL b2b_reserved: got %h expected ff", busy); n_fail++;
        end
        run = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                alu_valid = 1'b1; alu_addr = 3'(i); alu_data = 16'h0100 + 16'(i);
            end else begin
                alu_valid = 1'b0;
            end
            step();
            if (i < 8) begin
                n_tests++;
                if (wr_en !== 1'b1 || wr_addr !== 3'(i) || wr_data !== 16'h0100 + 16'(i)) begin
                    $display("FAIL b2b_write_%0d: got %b/%h/%h expected 1/%h/%h",
                             i, wr_en, wr_addr, wr_data, 3'(i), 16'h0100 + 16'(i));
                    n_fail++;
                end
                if (wr_en === 1'b1) run++;
            end
        end
        n_tests++;
        if (run !== 8 || wr_en !== 1'b0 || busy !== 8'h00) begin
            $display("FAIL b2b_final: got run=%0d wr_en=%b busy=%h expected 8 0 00", run, wr_en, busy);
            n_fail++;
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        n_tests++;
        if ({wr_en, wr_addr, wr_data, busy} !== '0 || iss_ready !== 1'b1) begin
            $display("FAIL init_reset: got wr_en=%b wr_addr=%h wr_data=%h busy=%h ready=%b",
                     wr_en, wr_addr, wr_data, busy, iss_ready);
            n_fail++;
        end
        rst = 1'b1;
        step();
        test_reset();
        test_alu_single();
        test_collision();
        test_waw_stall();
        test_set_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_commit
